// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared widths, FSM state encodings and address-field helpers
//            for the 2-way set-associative cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int LINE_W      = 512;
  localparam int INDEX_BITS  = 6;
  localparam int OFFSET_BITS = 6;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int WORD_BITS   = 4;
  localparam int NUM_SETS    = 1 << INDEX_BITS;

  // Controller states
  typedef logic [2:0] state_t;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] WR_REQ  = 3'd5;
  localparam logic [2:0] WR_WAIT = 3'd6;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [WORD_BITS-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[2 +: WORD_BITS];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_array
// Purpose  : Tag, valid and LRU storage for 64 sets x 2 ways with a
//            parallel 2-way tag compare. lru_store[set] names the victim way.
// Revision : 1.0 - initial release
// ============================================================================
module cache_tag_array
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic                  inval_en,
  input  logic                  fill_en,
  input  logic                  lru_touch_en,
  output logic                  hit,
  output logic                  hit_way
);

  logic [TAG_BITS-1:0] tag_store   [NUM_SETS][2];
  logic [1:0]          valid_store [NUM_SETS];
  logic [NUM_SETS-1:0] lru_store;

  logic hit_w0;
  logic hit_w1;
  logic victim;

  // Compare the addressed set in both ways; victim is the set's LRU way
  always_comb begin
    hit_w0  = valid_store[idx][0] && (tag_store[idx][0] == tag);
    hit_w1  = valid_store[idx][1] && (tag_store[idx][1] == tag);
    hit     = hit_w0 | hit_w1;
    hit_way = ~hit_w0;
    victim  = lru_store[idx];
  end

  // Valid and LRU bits: cleared on reset, updated by fill, touch and invalidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_store[s] <= 2'b00;
      end
      lru_store <= '0;
    end else begin
      if (fill_en) begin
        valid_store[idx][victim] <= 1'b1;
        lru_store[idx]           <= ~victim;
      end else if (lru_touch_en) begin
        lru_store[idx] <= ~hit_way;
      end
      if (inval_en) begin
        valid_store[idx][hit_way] <= 1'b0;
      end
    end
  end

  // Tags need no reset; they are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_store[idx][victim] <= tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_2way
// Purpose  : 2-way set-associative, write-through, no-write-allocate cache
//            controller between a CPU port, a line SRAM and main memory.
//            Optional macro CC_PERF_CNT_EN adds internal hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_2way
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic [DATA_W-1:0] data_from_cpu,
  input  logic              read_mem,
  input  logic              write_mem,
  output logic [DATA_W-1:0] data_to_cpu,
  output logic              hit_miss,
  output logic              ready_stall,
  output logic [INDEX_BITS-1:0] cache_mem_index,
  output logic [LINE_W-1:0] cache_mem_data_in,
  output logic              cache_mem_write_en,
  input  logic [LINE_W-1:0] cache_mem_data_out,
  output logic [ADDR_W-1:0] main_mem_addr,
  output logic [DATA_W-1:0] main_mem_data_out,
  output logic              main_mem_read_req,
  output logic              main_mem_write_req,
  input  logic [LINE_W-1:0] main_mem_data_in,
  input  logic              main_mem_ready
);

  logic [2:0]        state_q,       state_d;
  logic [ADDR_W-1:0] reg_phy_addr,  reg_phy_addr_d;
  logic [DATA_W-1:0] reg_wdata,     reg_wdata_d;
  logic              is_rd_q,       is_rd_d;
  logic [DATA_W-1:0] data_to_cpu_q, data_to_cpu_d;
  logic              hit_miss_q,    hit_miss_d;
  logic [LINE_W-1:0] line_q,        line_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;

  logic hit;
  logic hit_way;
  logic tag_inval;
  logic tag_fill;
  logic lru_touch;

  cache_tag_array u_tag_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx          (addr_index(reg_phy_addr)),
    .tag          (addr_tag(reg_phy_addr)),
    .inval_en     (tag_inval),
    .fill_en      (tag_fill),
    .lru_touch_en (lru_touch),
    .hit          (hit),
    .hit_way      (hit_way)
  );

  // Next-state and datapath decisions for the request sequence
  always_comb begin
    state_d        = state_q;
    reg_phy_addr_d = reg_phy_addr;
    reg_wdata_d    = reg_wdata;
    is_rd_d        = is_rd_q;
    data_to_cpu_d  = data_to_cpu_q;
    hit_miss_d     = hit_miss_q;
    line_d         = line_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    tag_inval      = 1'b0;
    tag_fill       = 1'b0;
    lru_touch      = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_mem || write_mem) begin
          reg_phy_addr_d = phy_addr;
          reg_wdata_d    = data_from_cpu;
          is_rd_d        = read_mem;
          state_d        = CHECK;
        end
      end
      CHECK: begin
        hit_miss_d = hit;
        if (is_rd_q) begin
          if (hit) begin
            data_to_cpu_d = cache_mem_data_out[{addr_word(reg_phy_addr), 5'b0} +: DATA_W];
            lru_touch     = 1'b1;
            state_d       = IDLE;
          end else begin
            mem_addr_d = {addr_tag(reg_phy_addr), addr_index(reg_phy_addr), {OFFSET_BITS{1'b0}}};
            state_d    = RD_REQ;
          end
        end else begin
          // Write-through: a hitting line is dropped rather than updated
          tag_inval   = hit;
          mem_addr_d  = reg_phy_addr & ~32'h3;
          mem_wdata_d = reg_wdata;
          state_d     = WR_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (main_mem_ready) begin
          line_d  = main_mem_data_in;
          state_d = FILL;
        end
      end
      FILL: begin
        tag_fill      = 1'b1;
        data_to_cpu_d = line_q[{addr_word(reg_phy_addr), 5'b0} +: DATA_W];
        state_d       = IDLE;
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (main_mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all controller state; reset abandons any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      reg_phy_addr  <= '0;
      reg_wdata     <= '0;
      is_rd_q       <= 1'b0;
      data_to_cpu_q <= '0;
      hit_miss_q    <= 1'b0;
      line_q        <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      reg_phy_addr  <= reg_phy_addr_d;
      reg_wdata     <= reg_wdata_d;
      is_rd_q       <= is_rd_d;
      data_to_cpu_q <= data_to_cpu_d;
      hit_miss_q    <= hit_miss_d;
      line_q        <= line_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

`ifdef CC_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Saturating lookup-outcome counters, one step per CHECK cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == CHECK) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters not built
`endif

  assign data_to_cpu        = data_to_cpu_q;
  assign hit_miss           = hit_miss_q;
  assign ready_stall        = (state_q != IDLE);
  assign cache_mem_index    = addr_index(reg_phy_addr);
  assign cache_mem_data_in  = line_q;
  assign cache_mem_write_en = (state_q == FILL);
  assign main_mem_addr      = mem_addr_q;
  assign main_mem_data_out  = mem_wdata_q;
  assign main_mem_read_req  = (state_q == RD_REQ);
  assign main_mem_write_req = (state_q == WR_REQ);

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_2way.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl_2way
// Purpose  : Directed self-checking bench for cache_ctrl_2way. Memory line k
//            holds k + (w << 24) in word w; the SRAM model returns the line
//            of the address currently presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_2way;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  phy_addr;
  logic [31:0]  data_from_cpu;
  logic         read_mem;
  logic         write_mem;
  logic [31:0]  data_to_cpu;
  logic         hit_miss;
  logic         ready_stall;
  logic [5:0]   cache_mem_index;
  logic [511:0] cache_mem_data_in;
  logic         cache_mem_write_en;
  logic [511:0] cache_mem_data_out;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  cache_ctrl_2way dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .phy_addr           (phy_addr),
    .data_from_cpu      (data_from_cpu),
    .read_mem           (read_mem),
    .write_mem          (write_mem),
    .data_to_cpu        (data_to_cpu),
    .hit_miss           (hit_miss),
    .ready_stall        (ready_stall),
    .cache_mem_index    (cache_mem_index),
    .cache_mem_data_in  (cache_mem_data_in),
    .cache_mem_write_en (cache_mem_write_en),
    .cache_mem_data_out (cache_mem_data_out),
    .main_mem_addr      (main_mem_addr),
    .main_mem_data_out  (main_mem_data_out),
    .main_mem_read_req  (main_mem_read_req),
    .main_mem_write_req (main_mem_write_req),
    .main_mem_data_in   (main_mem_data_in),
    .main_mem_ready     (main_mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [25:0] k);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {6'b0, k} + (32'(w) << 24);
    return l;
  endfunction

  assign cache_mem_data_out = mk_line(phy_addr[31:6]);

  task automatic test_reset();
    rst_n = 1'b0; phy_addr = '0; data_from_cpu = '0; read_mem = 1'b0;
    write_mem = 1'b0; main_mem_data_in = '0; main_mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if ({ready_stall, hit_miss, cache_mem_write_en, main_mem_read_req, main_mem_write_req} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b expected 00000", {ready_stall, hit_miss, cache_mem_write_en, main_mem_read_req, main_mem_write_req}); end
    vec_cnt++; if (data_to_cpu !== 32'h0 || main_mem_addr !== 32'h0 || main_mem_data_out !== 32'h0) begin
      err_cnt++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", data_to_cpu, main_mem_addr, main_mem_data_out); end
    vec_cnt++; if (cache_mem_index !== 6'h0 || cache_mem_data_in !== 512'h0) begin
      err_cnt++; $display("FAIL reset_sram: got idx %h expected 0", cache_mem_index); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss(input logic [31:0] addr, input logic [31:0] exp_line_addr,
                                input logic [5:0] exp_idx, input logic [31:0] exp_data);
    phy_addr = addr; read_mem = 1'b1;
    @(negedge clk); read_mem = 1'b0;
    vec_cnt++; if (ready_stall !== 1'b1) begin
      err_cnt++; $display("FAIL miss_stall_check %h: got %b expected 1", addr, ready_stall); end
    @(negedge clk);
    vec_cnt++; if (hit_miss !== 1'b0) begin
      err_cnt++; $display("FAIL miss_hit_miss %h: got %b expected 0", addr, hit_miss); end
    vec_cnt++; if (main_mem_read_req !== 1'b1 || main_mem_addr !== exp_line_addr) begin
      err_cnt++; $display("FAIL miss_read_req %h: got req %b addr %h expected 1 %h", addr, main_mem_read_req, main_mem_addr, exp_line_addr); end
    repeat (2) begin
      @(negedge clk);
      vec_cnt++; if (main_mem_read_req !== 1'b0 || main_mem_addr !== exp_line_addr || ready_stall !== 1'b1 || cache_mem_write_en !== 1'b0) begin
        err_cnt++; $display("FAIL miss_wait %h: got req %b addr %h stall %b we %b expected 0 %h 1 0", addr, main_mem_read_req, main_mem_addr, ready_stall, cache_mem_write_en, exp_line_addr); end
    end
    main_mem_data_in = mk_line(exp_line_addr[31:6]); main_mem_ready = 1'b1;
    @(negedge clk); main_mem_ready = 1'b0; main_mem_data_in = '0;
    vec_cnt++; if (cache_mem_write_en !== 1'b1 || cache_mem_index !== exp_idx || cache_mem_data_in !== mk_line(exp_line_addr[31:6])) begin
      err_cnt++; $display("FAIL miss_fill %h: got we %b idx %h expected 1 %h", addr, cache_mem_write_en, cache_mem_index, exp_idx); end
    @(negedge clk);
    vec_cnt++; if (ready_stall !== 1'b0 || cache_mem_write_en !== 1'b0 || hit_miss !== 1'b0) begin
      err_cnt++; $display("FAIL miss_done %h: got stall %b we %b hm %b expected 0 0 0", addr, ready_stall, cache_mem_write_en, hit_miss); end
    vec_cnt++; if (data_to_cpu !== exp_data) begin
      err_cnt++; $display("FAIL miss_data %h: got %h expected %h", addr, data_to_cpu, exp_data); end
  endtask

  task automatic test_read_hit(input logic [31:0] addr, input logic also_write, input logic [31:0] exp_data);
    phy_addr = addr; read_mem = 1'b1; write_mem = also_write;
    @(negedge clk); read_mem = 1'b0; write_mem = 1'b0;
    vec_cnt++; if (ready_stall !== 1'b1) begin
      err_cnt++; $display("FAIL hit_stall_check %h: got %b expected 1", addr, ready_stall); end
    @(negedge clk);
    vec_cnt++; if (hit_miss !== 1'b1 || ready_stall !== 1'b0 || main_mem_write_req !== 1'b0 || main_mem_read_req !== 1'b0) begin
      err_cnt++; $display("FAIL hit_status %h: got hm %b stall %b wr %b rd %b expected 1 0 0 0", addr, hit_miss, ready_stall, main_mem_write_req, main_mem_read_req); end
    vec_cnt++; if (data_to_cpu !== exp_data) begin
      err_cnt++; $display("FAIL hit_data %h: got %h expected %h", addr, data_to_cpu, exp_data); end
  endtask

  task automatic test_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_addr, input logic exp_hit);
    phy_addr = addr; data_from_cpu = wdata; write_mem = 1'b1;
    @(negedge clk); write_mem = 1'b0;
    @(negedge clk);
    vec_cnt++; if (hit_miss !== exp_hit) begin
      err_cnt++; $display("FAIL wr_hit_miss %h: got %b expected %b", addr, hit_miss, exp_hit); end
    vec_cnt++; if (main_mem_write_req !== 1'b1 || main_mem_addr !== exp_addr || main_mem_data_out !== wdata) begin
      err_cnt++; $display("FAIL wr_req %h: got req %b addr %h data %h expected 1 %h %h", addr, main_mem_write_req, main_mem_addr, main_mem_data_out, exp_addr, wdata); end
    repeat (2) begin
      @(negedge clk);
      vec_cnt++; if (main_mem_write_req !== 1'b0 || ready_stall !== 1'b1 || cache_mem_write_en !== 1'b0 || main_mem_data_out !== wdata) begin
        err_cnt++; $display("FAIL wr_wait %h: got req %b stall %b we %b data %h expected 0 1 0 %h", addr, main_mem_write_req, ready_stall, cache_mem_write_en, main_mem_data_out, wdata); end
    end
    main_mem_ready = 1'b1;
    @(negedge clk); main_mem_ready = 1'b0;
    vec_cnt++; if (ready_stall !== 1'b0 || cache_mem_write_en !== 1'b0) begin
      err_cnt++; $display("FAIL wr_done %h: got stall %b we %b expected 0 0", addr, ready_stall, cache_mem_write_en); end
  endtask

  task automatic test_reset_mid_transaction();
    phy_addr = 32'h5000; read_mem = 1'b1;
    @(negedge clk); read_mem = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (ready_stall !== 1'b1 || main_mem_addr !== 32'h5000) begin
      err_cnt++; $display("FAIL rst_pre_wait: got stall %b addr %h expected 1 00005000", ready_stall, main_mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (ready_stall !== 1'b0 || main_mem_addr !== 32'h0 || data_to_cpu !== 32'h0) begin
      err_cnt++; $display("FAIL rst_async: got stall %b addr %h data %h expected 0 0 0", ready_stall, main_mem_addr, data_to_cpu); end
    @(negedge clk); rst_n = 1'b1;
    main_mem_data_in = mk_line(26'h140); main_mem_ready = 1'b1;
    @(negedge clk); main_mem_ready = 1'b0; main_mem_data_in = '0;
    @(negedge clk);
    vec_cnt++; if (ready_stall !== 1'b0 || cache_mem_write_en !== 1'b0 || data_to_cpu !== 32'h0) begin
      err_cnt++; $display("FAIL rst_late_ready: got stall %b we %b data %h expected 0 0 0", ready_stall, cache_mem_write_en, data_to_cpu); end
  endtask

  initial begin
    test_reset();
    test_read_miss(32'h0000_1000, 32'h0000_1000, 6'd0, 32'h0000_0040);  // way0, lru->1
    test_read_hit (32'h0000_1000, 1'b0, 32'h0000_0040);
    test_write    (32'h0000_2000, 32'hCAFE_BABE, 32'h0000_2000, 1'b0);
    test_read_miss(32'h0004_1000, 32'h0004_1000, 6'd0, 32'h0000_1040);  // way1, lru->0
    test_read_miss(32'h0008_1000, 32'h0008_1000, 6'd0, 32'h0000_2040);  // evicts tag 1
    test_read_miss(32'h0000_1000, 32'h0000_1000, 6'd0, 32'h0000_0040);  // evicts tag 0x41
    test_read_hit (32'h0008_103C, 1'b1, 32'h0F00_2040);                 // read wins over write
    test_read_hit (32'h0000_1000, 1'b0, 32'h0000_0040);                 // lru->0
    test_write    (32'h0000_1003, 32'h1234_5678, 32'h0000_1000, 1'b1);  // invalidates tag 1
    test_read_miss(32'h0000_1008, 32'h0000_1000, 6'd0, 32'h0200_0040);  // refills way0 (evicts 0x81)
    test_read_miss(32'h0008_1000, 32'h0008_1000, 6'd0, 32'h0000_2040);
    test_read_miss(32'h0000_1040, 32'h0000_1040, 6'd1, 32'h0000_0041);
    test_reset_mid_transaction();
    test_read_miss(32'h0000_1000, 32'h0000_1000, 6'd0, 32'h0000_0040);
    test_read_hit (32'h0000_1000, 1'b0, 32'h0000_0040);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Controller for a 2-way set-associative cache: 64 sets, 64-byte (512-bit) lines, 32-bit physical addresses.
- Sits between the CPU load/store port and two external blocks: a 512-bit cache data SRAM and a main memory.
- Keeps tag, valid and LRU state internally.
- Write-through, no-write-allocate; read misses fill the LRU victim way.

Parameters:
- ADDR_W, 32, physical address width
- DATA_W, 32, CPU word width
- LINE_W, 512, cache line width
- INDEX_BITS, 6, set index width (64 sets)
- OFFSET_BITS, 6, byte offset within a line
- TAG_BITS, 20, ADDR_W-INDEX_BITS-OFFSET_BITS

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- phy_addr  in  32  CPU address; tag [31:12], index [11:6], word [5:2]
- data_from_cpu  in  32  store data
- read_mem  in  1  load request, sampled in IDLE
- write_mem  in  1  store request, sampled in IDLE
- data_to_cpu  out  32  load result (registered)
- hit_miss  out  1  1 = last lookup hit (registered)
- ready_stall  out  1  1 = busy/stall, 0 = ready
- cache_mem_index  out  6  SRAM set index
- cache_mem_data_in  out  512  SRAM fill data
- cache_mem_write_en  out  1  SRAM write strobe; the SRAM writes way lru_store[index]
- cache_mem_data_out  in  512  SRAM read data, combinational, for the hitting way
- main_mem_addr  out  32  memory address
- main_mem_data_out  out  32  memory write word
- main_mem_read_req  out  1  line read request (1-cycle pulse)
- main_mem_write_req  out  1  word write request (1-cycle pulse)
- main_mem_data_in  in  512  line read data, valid with ready
- main_mem_ready  in  1  1-cycle completion pulse

Behaviour:
- Reset:
  - State returns to IDLE.
  - All valid bits and LRU bits clear (way 0 is the first victim).
  - All outputs are 0.
  - Reset mid-transaction abandons it; any late main_mem_ready is ignored in IDLE.
- Internal arrays:
  - tag_store[64][2], valid_store[64][2].
  - lru_store[64]: 1 bit per set naming the victim way. Must be named lru_store, together with latched reg_phy_addr.
- ready_stall = (state != IDLE).
- cache_mem_index = reg_phy_addr[11:6] always.
- IDLE:
  - On read_mem (read_mem has priority over write_mem), latch reg_phy_addr and reg_wdata and go to CHECK.
  - On write_mem, latch the same and go to CHECK.
- CHECK (one cycle):
  - hit = valid & tag match in either way.
  - Register hit_miss = hit.
  - Read hit: data_to_cpu <= cache_mem_data_out[word*32 +: 32], lru_store[idx] <= ~hit_way, go to IDLE. Total latency is 2 edges.
  - Read miss: go to RD_REQ.
  - Write hit: clear valid of the hitting way (no SRAM write), go to WR_REQ.
  - Write miss: go to WR_REQ.
- RD_REQ:
  - main_mem_read_req = 1 for one cycle, main_mem_addr = {tag, index, 6'b0}.
  - Go to RD_WAIT.
- RD_WAIT:
  - Hold main_mem_addr.
  - On main_mem_ready, register the line and go to FILL.
- FILL (one cycle):
  - cache_mem_write_en = 1, cache_mem_data_in = line.
  - lru_store[idx] still names the victim during this cycle.
  - On the edge: tag_store[idx][victim] <= tag, valid <= 1, lru_store[idx] <= ~victim, data_to_cpu <= line word.
  - Go to IDLE; hit_miss stays 0.
- WR_REQ:
  - main_mem_write_req = 1 for one cycle, main_mem_addr = {reg_phy_addr[31:2], 2'b00}, main_mem_data_out = reg_wdata.
  - Go to WR_WAIT.
- WR_WAIT:
  - Hold main_mem_addr and main_mem_data_out.
  - On main_mem_ready, go to IDLE.
  - LRU is unchanged on writes.
- Requests while busy are ignored; the CPU holds off until ready_stall is 0.
- hit_miss and data_to_cpu hold their values until the next CHECK or FILL.
- Main memory latency is unbounded; there is no timeout.

Optional Feature:
- Macro: CC_PERF_CNT_EN.
- When defined: internal 32-bit counters hit_cnt and miss_cnt increment in CHECK, for reads and writes. They clear on reset, saturate at all-ones, and are visible hierarchically only (no ports).
- When undefined: no counters; ports and behaviour are identical.

Decomposition:
- Package cache_pkg:
  - Width constants.
  - State enum: IDLE, CHECK, RD_REQ, RD_WAIT, FILL, WR_REQ, WR_WAIT.
  - Address field helper functions for tag, index and word.
- Sub-module cache_tag_array: tag, valid and lru storage with a 2-way compare, producing hit and hit_way.
- FSM and datapath remain in cache_ctrl_2way.

Test Plan:
- After reset, read 0x0000_1000 → miss: read_req with main_mem_addr 0x1000, FILL writes index 0 way 0; ready_stall goes 1 then 0; data_to_cpu = 64 (memory line k holds k in word 0).
- Read 0x1000 again → one cycle after the request edge, hit_miss=1, ready_stall=0, data_to_cpu=64, lru_store[0]=1.
- Write 0x2000 / 0xCAFEBABE → miss: write_req with addr 0x2000 and data 0xCAFEBABE, no cache write, ready_stall 1 until ready.
- Read 0x41000 → miss, fills way 1 of set 0. Read 0x81000 → miss, evicts way 0 (tag 0x00001).
- Read 0x1000 → hit_miss=0 one cycle after the request; refill completes with data 64.
- Assert rst_n low during RD_WAIT → ready_stall=0 immediately; a subsequent read of 0x1000 misses.
